shift_aes_core: RTL and testbench
=================================

# shift_aes_core

Parametrised, handshake-driven iterative ShiftAES block-cipher engine. It executes one cipher round per clock with on-the-fly AES-128 key expansion, and supports 64-bit and 128-bit blocks and a configurable round count. It replaces the fixed-latency, handshake-free 64-bit encryptor. Upstream logic (bus bridge or DMA) drives it through valid/ready on both sides.

## Interface
- `BLOCK_W`, default 64: block width in bits; legal values are 64 or 128.
- `ROUNDS`, default 10: number of cipher rounds, 1..10.
- `clk` in 1: rising-edge clock.
- `reset_n` in 1: asynchronous, active-low reset. One clock; reset is asynchronous and active-low.
- `in_valid` in 1: plaintext and key are presented.
- `in_ready` out 1: core can accept a block.
- `plaintext` in BLOCK_W: input block; byte 0 is the MSB.
- `key` in 128: cipher key; byte 0 is the MSB.
- `out_valid` out 1: ciphertext is available.
- `out_ready` in 1: consumer accepts the ciphertext.
- `ciphertext` out BLOCK_W: result. Held stable while `out_valid` is high and `out_ready` is low.
- `abort` in 1: present only with `SHIFT_AES_ABORT_EN`.

## Operation
- **State matrix:** 4 rows × C columns, where C = BLOCK_W/32. Bytes are filled column-major, byte 0 first.
- **Round function**, applied in this order:
  - SubBytes using the AES S-box.
  - ShiftRows: row r rotates left by (r mod C) columns.
  - MixColumns (AES GF(2^8), polynomial 0x11B), skipped on the final round.
  - AddRoundKey.
- **Round keys:** round key i is the upper BLOCK_W bits of the 128-bit AES-128 expanded key i, with Rcon[i] for i = 1..ROUNDS. One key-expansion step is computed per cycle from the key register.
- **FSM states:** IDLE, ROUND, DONE.
  - IDLE: `in_ready` = 1. When `in_valid` && `in_ready`:
    - state ← `plaintext` ^ rk0
    - key register ← `key`
    - round counter ← 1
    - go to ROUND.
  - ROUND: each cycle applies round[counter] and increments the counter. When counter == ROUNDS, go to DONE after applying the final round.
  - DONE: `out_valid` = 1. On `out_ready`, go to IDLE.
- The round counter is $clog2(ROUNDS+1) bits wide and does not wrap; its range is bounded by the FSM.
- While not in IDLE, `plaintext`/`key` changes are ignored; the inputs are captured only at acceptance.
- Reset values: FSM = IDLE, `in_ready` = 1, `out_valid` = 0, `ciphertext` = 0, counter = 0, key register = 0.
- Reset asserted mid-operation: the block is discarded and the core returns immediately to IDLE. There is no partial output.

## Timing
- Acceptance edge T.
- Rounds execute on edges T+1 .. T+ROUNDS.
- `out_valid` rises after edge T+ROUNDS, i.e. latency is ROUNDS cycles.
- Earliest next acceptance is the edge after the output handshake. Throughput is one block per ROUNDS+2 cycles when `out_ready` is held high.
- `in_ready` is low from T+1 until the cycle after the output handshake.
- `out_ready` high while `out_valid` is low has no effect.
- `out_valid` and `ciphertext` remain stable indefinitely under backpressure.

## Configuration
- `SHIFT_AES_ABORT_EN` defined:
  - Adds the `abort` input.
  - `abort` high at a clock edge in ROUND or DONE forces IDLE, clears `out_valid`, and discards the result.
  - In IDLE, `abort` has no effect. If `abort` and `in_valid` are high together in IDLE, the block is accepted.
- Macro undefined: the port is absent and in-flight operations always complete.

## Structure
- **Package `shift_aes_pkg`:**
  - S-box function
  - Rcon table (10 entries)
  - `xtime` / MixColumn function
  - FSM state typedef (IDLE, ROUND, DONE)
  - parameter legality checks
- **Sub-module `shift_aes_round`:** combinational single round, parametrised by BLOCK_W, with a `last_round` input that bypasses MixColumns. The top level instantiates it once and owns the FSM, state register and key register.

## Test plan
- **FIPS-197 vector** (BLOCK_W=128, ROUNDS=10): `plaintext` 00112233445566778899aabbccddeeff, `key` 000102030405060708090a0b0c0d0e0f → `ciphertext` 69c4e0d86a7b0430d8cdb78070b4c55a, with `out_valid` exactly 10 cycles after acceptance.
- **64-bit vector** (BLOCK_W=64): `plaintext` 0123456789abcdef, `key` 00112233445566778899aabbccddeeff → output matches the bit-exact C reference model. `in_ready` stays low throughout; `plaintext` is changed mid-run with no effect on the result.
- **Backpressure:** hold `out_ready` = 0 for 20 cycles after `out_valid` → `ciphertext` stable and `in_ready` = 0. Release → handshake, then `in_ready` = 1 on the next cycle.
- **Back-to-back:** two blocks with `out_ready` tied to 1 → second acceptance occurs ROUNDS+2 cycles after the first, and both results match the model.
- **Reset mid-round:** drive `reset_n` low at round 5 → outputs immediately return to reset values. A new block then completes correctly.
- **Abort** (`SHIFT_AES_ABORT_EN`): pulse `abort` in ROUND, then separately in DONE → IDLE is reached the next cycle with `out_valid` = 0. With the macro undefined, the build has no `abort` port.

Source files
------------

// File: rtl/shift_aes_pkg.sv
// ShiftAES shared definitions: AES S-box, Rcon, MixColumn arithmetic, key
// expansion step, FSM state type and parameter legality check.
// Pure combinational helpers; no latency, no flow control of their own.
package shift_aes_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ROUND = 2'd1,
        DONE  = 2'd2
    } state_e;

    // Byte 0x00 sits in the top byte; indexed with the complemented value.
    localparam logic [255:0][7:0] SBOX_TAB = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    function automatic logic [7:0] sbox(input logic [7:0] b);
        return SBOX_TAB[~b];
    endfunction

    function automatic logic [7:0] rcon(input logic [3:0] i);
        case (i)
            4'd1:    return 8'h01;
            4'd2:    return 8'h02;
            4'd3:    return 8'h04;
            4'd4:    return 8'h08;
            4'd5:    return 8'h10;
            4'd6:    return 8'h20;
            4'd7:    return 8'h40;
            4'd8:    return 8'h80;
            4'd9:    return 8'h1b;
            4'd10:   return 8'h36;
            default: return 8'h00;
        endcase
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    // Column bytes are ordered row 0 in the top byte.
    function automatic logic [31:0] mix_column(input logic [31:0] col);
        logic [7:0] a0, a1, a2, a3;
        {a0, a1, a2, a3} = col;
        return {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
                a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
                a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
                xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
    endfunction

    function automatic logic [31:0] sub_word(input logic [31:0] w);
        return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
    endfunction

    // One AES-128 key-schedule step: expanded key i-1 -> expanded key i.
    function automatic logic [127:0] key_expand(input logic [127:0] k, input logic [7:0] rc);
        logic [31:0] t, n0, n1, n2, n3;
        t  = sub_word({k[23:0], k[31:24]}) ^ {rc, 24'h000000};
        n0 = k[127:96] ^ t;
        n1 = k[95:64]  ^ n0;
        n2 = k[63:32]  ^ n1;
        n3 = k[31:0]   ^ n2;
        return {n0, n1, n2, n3};
    endfunction

    function automatic bit params_legal(input int block_w, input int rounds);
        return ((block_w == 64) || (block_w == 128)) && (rounds >= 1) && (rounds <= 10);
    endfunction

endpackage

// File: rtl/shift_aes_round.sv
// One ShiftAES round: SubBytes, ShiftRows, MixColumns (skipped when last_round), AddRoundKey.
// Purely combinational, zero latency; no flow control.
// Ports: state_in/round_key (BLOCK_W), last_round -> state_out (BLOCK_W).
module shift_aes_round
    import shift_aes_pkg::*;
#(
    parameter int BLOCK_W = 64
) (
    input  logic [BLOCK_W-1:0] state_in,
    input  logic [BLOCK_W-1:0] round_key,
    input  logic               last_round,
    output logic [BLOCK_W-1:0] state_out
);

    localparam int COLS = BLOCK_W / 32;

    logic [7:0]         sb [4][COLS];
    logic [BLOCK_W-1:0] mixed;

    // Byte k of the block lives at row k%4, column k/4; byte 0 is the MSB.
    for (genvar c = 0; c < COLS; c++) begin : g_sub_col
        for (genvar r = 0; r < 4; r++) begin : g_sub_row
            assign sb[r][c] = sbox(state_in[BLOCK_W-1-8*(4*c+r) -: 8]);
        end
    end

    // Row r rotates left by r mod COLS, so output column c takes row r
    // from input column (c + r) mod COLS.
    for (genvar c = 0; c < COLS; c++) begin : g_col
        logic [31:0] shifted;
        assign shifted = {sb[0][c % COLS],       sb[1][(c + 1) % COLS],
                          sb[2][(c + 2) % COLS], sb[3][(c + 3) % COLS]};
        assign mixed[BLOCK_W-1-32*c -: 32] = last_round ? shifted : mix_column(shifted);
    end

    assign state_out = mixed ^ round_key;

endmodule

// File: rtl/shift_aes_core.sv
// Iterative ShiftAES engine, one round per clock, AES-128 key expansion on the fly.
// Latency ROUNDS cycles from acceptance to out_valid; one block per ROUNDS+2 cycles.
// Backpressure: holds DONE with ciphertext stable until out_ready; in_ready low while busy.
// Ports: clk, reset_n (async, active-low), in_valid/in_ready + plaintext/key,
//        out_valid/out_ready + ciphertext; abort only when SHIFT_AES_ABORT_EN is defined.
module shift_aes_core
    import shift_aes_pkg::*;
#(
    parameter int BLOCK_W = 64,
    parameter int ROUNDS  = 10
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [BLOCK_W-1:0] plaintext,
    input  logic [127:0]       key,
`ifdef SHIFT_AES_ABORT_EN
    input  logic               abort,
`endif
    output logic               out_valid,
    input  logic               out_ready,
    output logic [BLOCK_W-1:0] ciphertext
);

    localparam int CNT_W = $clog2(ROUNDS + 1);

    if (!params_legal(BLOCK_W, ROUNDS)) begin : g_bad_params
        $error("shift_aes_core: BLOCK_W must be 64 or 128 and ROUNDS 1..10");
    end

    state_e             state_q, state_d;
    logic [BLOCK_W-1:0] data_q;
    logic [BLOCK_W-1:0] round_out;
    logic [127:0]       key_q;
    logic [127:0]       key_next;
    logic [CNT_W-1:0]   cnt_q;
    logic               last_round;
    logic               abort_now;

`ifdef SHIFT_AES_ABORT_EN
    assign abort_now = abort;
`else
    assign abort_now = 1'b0;
`endif

    assign last_round = (cnt_q == CNT_W'(ROUNDS));
    // Round key for the round being applied is derived from the previous one.
    assign key_next   = key_expand(key_q, rcon(4'(cnt_q)));

    shift_aes_round #(
        .BLOCK_W (BLOCK_W)
    ) u_round (
        .state_in   (data_q),
        .round_key  (key_next[127 -: BLOCK_W]),
        .last_round (last_round),
        .state_out  (round_out)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state_q)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) state_d = ROUND;
            end
            ROUND: begin
                if (last_round) state_d = DONE;
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        // Abort wins over any in-flight progress but never blocks acceptance.
        if (abort_now && (state_q != IDLE)) state_d = IDLE;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            data_q <= '0;
            key_q  <= '0;
            cnt_q  <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        data_q <= plaintext ^ key[127 -: BLOCK_W];
                        key_q  <= key;
                        cnt_q  <= CNT_W'(1);
                    end
                end
                ROUND: begin
                    data_q <= round_out;
                    key_q  <= key_next;
                    if (!last_round) cnt_q <= cnt_q + 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign ciphertext = data_q;

endmodule

// File: tb/tb_shift_aes_core.sv
module tb_shift_aes_core;

    localparam int ROUNDS = 10;

    logic         clk = 1'b0;
    logic         reset_n;
    logic         in_valid;
    logic         out_ready;
    logic [127:0] pt;
    logic [127:0] key;
    logic         ir128, ov128, ir64, ov64;
    logic [127:0] ct128;
    logic [63:0]  ct64;
`ifdef SHIFT_AES_ABORT_EN
    logic         abort;
`endif

    int checks = 0;
    int errors = 0;

    logic [7:0] sbox_m [256];

    always #5 clk = ~clk;

    shift_aes_core #(.BLOCK_W(128), .ROUNDS(ROUNDS)) dut128 (
        .clk        (clk),
        .reset_n    (reset_n),
        .in_valid   (in_valid),
        .in_ready   (ir128),
        .plaintext  (pt),
        .key        (key),
`ifdef SHIFT_AES_ABORT_EN
        .abort      (abort),
`endif
        .out_valid  (ov128),
        .out_ready  (out_ready),
        .ciphertext (ct128)
    );

    shift_aes_core #(.BLOCK_W(64), .ROUNDS(ROUNDS)) dut64 (
        .clk        (clk),
        .reset_n    (reset_n),
        .in_valid   (in_valid),
        .in_ready   (ir64),
        .plaintext  (pt[127:64]),
        .key        (key),
`ifdef SHIFT_AES_ABORT_EN
        .abort      (abort),
`endif
        .out_valid  (ov64),
        .out_ready  (out_ready),
        .ciphertext (ct64)
    );

    // ---------------- reference model ----------------
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, x, y;
        p = 8'h00; x = a; y = b;
        for (int i = 0; i < 8; i++) begin
            if (y[0]) p = p ^ x;
            x = x[7] ? ({x[6:0], 1'b0} ^ 8'h1b) : {x[6:0], 1'b0};
            y = {1'b0, y[7:1]};
        end
        return p;
    endfunction

    // S-box from its definition: GF(2^8) inverse (x^254) followed by the affine map.
    task automatic build_sbox;
        logic [7:0] inv, t, s;
        for (int v = 0; v < 256; v++) begin
            inv = 8'h01;
            for (int i = 0; i < 254; i++) inv = gmul(inv, 8'(v));
            s = inv; t = inv;
            for (int i = 0; i < 4; i++) begin
                t = {t[6:0], t[7]};
                s = s ^ t;
            end
            sbox_m[v] = s ^ 8'h63;
        end
    endtask

    // Result in the top bw bits; plaintext taken from the top bw bits of p.
    function automatic logic [127:0] ref_encrypt(input logic [127:0] p, input logic [127:0] k, input int bw);
        logic [7:0]   st  [16];
        logic [7:0]   tmp [16];
        logic [31:0]  w   [44];
        logic [7:0]   a   [4];
        logic [31:0]  t;
        logic [7:0]   rc;
        logic [127:0] res;
        int nc;
        nc = bw / 32;
        rc = 8'h01;
        for (int i = 0; i < 4; i++) w[i] = k[127-32*i -: 32];
        for (int i = 4; i < 44; i++) begin
            t = w[i-1];
            if (i % 4 == 0) begin
                t = {sbox_m[t[23:16]], sbox_m[t[15:8]], sbox_m[t[7:0]], sbox_m[t[31:24]]} ^ {rc, 24'h0};
                rc = gmul(rc, 8'h02);
            end
            w[i] = w[i-4] ^ t;
        end
        for (int b = 0; b < 16; b++) st[b] = p[127-8*b -: 8];
        for (int rd = 0; rd <= ROUNDS; rd++) begin
            if (rd > 0) begin
                for (int b = 0; b < 4*nc; b++) st[b] = sbox_m[st[b]];
                for (int c = 0; c < nc; c++)
                    for (int r = 0; r < 4; r++) tmp[4*c+r] = st[4*((c + r) % nc) + r];
                for (int b = 0; b < 4*nc; b++) st[b] = tmp[b];
                if (rd != ROUNDS) begin
                    for (int c = 0; c < nc; c++) begin
                        for (int r = 0; r < 4; r++) a[r] = st[4*c+r];
                        st[4*c+0] = gmul(a[0], 8'h02) ^ gmul(a[1], 8'h03) ^ a[2] ^ a[3];
                        st[4*c+1] = a[0] ^ gmul(a[1], 8'h02) ^ gmul(a[2], 8'h03) ^ a[3];
                        st[4*c+2] = a[0] ^ a[1] ^ gmul(a[2], 8'h02) ^ gmul(a[3], 8'h03);
                        st[4*c+3] = gmul(a[0], 8'h03) ^ a[1] ^ a[2] ^ gmul(a[3], 8'h02);
                    end
                end
            end
            for (int c = 0; c < nc; c++)
                for (int r = 0; r < 4; r++) st[4*c+r] = st[4*c+r] ^ w[4*rd+c][31-8*r -: 8];
        end
        res = '0;
        for (int b = 0; b < 4*nc; b++) res[127-8*b -: 8] = st[b];
        return res;
    endfunction

    function automatic logic [127:0] rand128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // ---------------- stimulus helpers (no checking) ----------------
    task automatic accept_block(input logic [127:0] p, input logic [127:0] k);
        pt = p; key = k; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    // Edges counted from the acceptance edge until both cores show out_valid.
    task automatic wait_valid(output int n);
        n = 0;
        while (!(ov128 && ov64) && n < 40) begin
            @(posedge clk); #1;
            n++;
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset;
        reset_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; pt = '0; key = '0;
`ifdef SHIFT_AES_ABORT_EN
        abort = 1'b0;
`endif
        repeat (2) @(posedge clk);
        #1;
        checks++; if (ir128 !== 1'b1) begin errors++; $display("FAIL reset_in_ready128 got %b want 1", ir128); end
        checks++; if (ov128 !== 1'b0) begin errors++; $display("FAIL reset_out_valid128 got %b want 0", ov128); end
        checks++; if (ct128 !== '0) begin errors++; $display("FAIL reset_ct128 got %h want 0", ct128); end
        checks++; if (ir64 !== 1'b1) begin errors++; $display("FAIL reset_in_ready64 got %b want 1", ir64); end
        checks++; if (ov64 !== 1'b0) begin errors++; $display("FAIL reset_out_valid64 got %b want 0", ov64); end
        checks++; if (ct64 !== '0) begin errors++; $display("FAIL reset_ct64 got %h want 0", ct64); end
        reset_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_fips;
        logic [127:0] p, k, e64;
        int n;
        p = 128'h00112233445566778899aabbccddeeff;
        k = 128'h000102030405060708090a0b0c0d0e0f;
        e64 = ref_encrypt(p, k, 64);
        accept_block(p, k);
        checks++; if (ir128 !== 1'b0) begin errors++; $display("FAIL fips_busy_in_ready got %b want 0", ir128); end
        wait_valid(n);
        checks++; if (n !== ROUNDS) begin errors++; $display("FAIL fips_latency got %0d want %0d", n, ROUNDS); end
        checks++; if (ct128 !== 128'h69c4e0d86a7b0430d8cdb78070b4c55a) begin
            errors++; $display("FAIL fips_ct128 got %h want 69c4e0d86a7b0430d8cdb78070b4c55a", ct128);
        end
        checks++; if (ct64 !== e64[127:64]) begin errors++; $display("FAIL fips_ct64 got %h want %h", ct64, e64[127:64]); end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        checks++; if (ov128 !== 1'b0 || ov64 !== 1'b0) begin errors++; $display("FAIL fips_post_hs_valid got %b%b want 00", ov128, ov64); end
        checks++; if (ir128 !== 1'b1 || ir64 !== 1'b1) begin errors++; $display("FAIL fips_post_hs_ready got %b%b want 11", ir128, ir64); end
    endtask

    task automatic test_vec64;
        logic [127:0] p, k, e128, e64;
        int n;
        bit busy_ok;
        p = {64'h0123456789abcdef, $urandom, $urandom};
        k = 128'h00112233445566778899aabbccddeeff;
        e128 = ref_encrypt(p, k, 128);
        e64  = ref_encrypt(p, k, 64);
        accept_block(p, k);
        busy_ok = 1'b1;
        n = 0;
        while (!(ov128 && ov64) && n < 40) begin
            if (ir128 !== 1'b0 || ir64 !== 1'b0) busy_ok = 1'b0;
            if (n == 3) begin pt = rand128(); key = rand128(); end
            @(posedge clk); #1;
            n++;
        end
        checks++; if (!busy_ok) begin errors++; $display("FAIL vec64_in_ready_busy got high want low"); end
        checks++; if (n !== ROUNDS) begin errors++; $display("FAIL vec64_latency got %0d want %0d", n, ROUNDS); end
        checks++; if (ct64 !== e64[127:64]) begin errors++; $display("FAIL vec64_ct64 got %h want %h", ct64, e64[127:64]); end
        checks++; if (ct128 !== e128) begin errors++; $display("FAIL vec64_ct128 got %h want %h", ct128, e128); end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    task automatic test_backpressure;
        logic [127:0] p, k, e128, e64;
        int n;
        bit stable_ok;
        p = rand128(); k = rand128();
        e128 = ref_encrypt(p, k, 128);
        e64  = ref_encrypt(p, k, 64);
        accept_block(p, k);
        wait_valid(n);
        checks++; if (n !== ROUNDS) begin errors++; $display("FAIL bp_latency got %0d want %0d", n, ROUNDS); end
        stable_ok = 1'b1;
        pt = rand128(); key = rand128(); in_valid = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            if (ct128 !== e128 || ct64 !== e64[127:64] || ov128 !== 1'b1 || ov64 !== 1'b1
                || ir128 !== 1'b0 || ir64 !== 1'b0) stable_ok = 1'b0;
        end
        in_valid = 1'b0;
        checks++; if (!stable_ok) begin errors++; $display("FAIL bp_hold got ct=%h ov=%b ir=%b want ct=%h ov=1 ir=0", ct128, ov128, ir128, e128); end
        checks++; if (ct64 !== e64[127:64]) begin errors++; $display("FAIL bp_ct64 got %h want %h", ct64, e64[127:64]); end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        checks++; if (ir128 !== 1'b1 || ir64 !== 1'b1 || ov128 !== 1'b0 || ov64 !== 1'b0) begin
            errors++; $display("FAIL bp_release got ir=%b%b ov=%b%b want ir=11 ov=00", ir128, ir64, ov128, ov64);
        end
    endtask

    task automatic test_back_to_back;
        logic [127:0] p [2];
        logic [127:0] k [2];
        logic [127:0] e;
        logic [127:0] got128 [$];
        logic [63:0]  got64  [$];
        int acc [$];
        int t;
        bit acc_now;
        for (int i = 0; i < 2; i++) begin p[i] = rand128(); k[i] = rand128(); end
        out_ready = 1'b1;
        pt = p[0]; key = k[0]; in_valid = 1'b1;
        t = 0;
        while ((acc.size() < 2 || got128.size() < 2) && t < 80) begin
            acc_now = in_valid && ir128 && ir64;
            @(posedge clk); #1;
            t++;
            if (acc_now) begin
                acc.push_back(t);
                if (acc.size() == 1) begin pt = p[1]; key = k[1]; end
                else in_valid = 1'b0;
            end
            if (ov128 && ov64) begin got128.push_back(ct128); got64.push_back(ct64); end
        end
        in_valid = 1'b0;
        out_ready = 1'b0;
        checks++;
        if (acc.size() != 2 || got128.size() != 2) begin
            errors++; $display("FAIL b2b_progress got acc=%0d out=%0d want 2 2", acc.size(), got128.size());
        end else begin
            checks++; if (acc[1] - acc[0] !== ROUNDS + 2) begin
                errors++; $display("FAIL b2b_spacing got %0d want %0d", acc[1] - acc[0], ROUNDS + 2);
            end
            for (int i = 0; i < 2; i++) begin
                e = ref_encrypt(p[i], k[i], 128);
                checks++; if (got128[i] !== e) begin errors++; $display("FAIL b2b_ct128_%0d got %h want %h", i, got128[i], e); end
                e = ref_encrypt(p[i], k[i], 64);
                checks++; if (got64[i] !== e[127:64]) begin errors++; $display("FAIL b2b_ct64_%0d got %h want %h", i, got64[i], e[127:64]); end
            end
        end
    endtask

    task automatic test_reset_mid;
        logic [127:0] p, k, e128, e64;
        int n;
        accept_block(rand128(), rand128());
        repeat (4) @(posedge clk);
        #1;
        reset_n = 1'b0;
        #1;
        checks++; if (ir128 !== 1'b1 || ir64 !== 1'b1) begin errors++; $display("FAIL rstmid_in_ready got %b%b want 11", ir128, ir64); end
        checks++; if (ov128 !== 1'b0 || ov64 !== 1'b0) begin errors++; $display("FAIL rstmid_out_valid got %b%b want 00", ov128, ov64); end
        checks++; if (ct128 !== '0 || ct64 !== '0) begin errors++; $display("FAIL rstmid_ct got %h %h want 0 0", ct128, ct64); end
        @(posedge clk); #1;
        reset_n = 1'b1;
        @(posedge clk); #1;
        p = rand128(); k = rand128();
        e128 = ref_encrypt(p, k, 128);
        e64  = ref_encrypt(p, k, 64);
        accept_block(p, k);
        wait_valid(n);
        checks++; if (n !== ROUNDS) begin errors++; $display("FAIL rstmid_latency got %0d want %0d", n, ROUNDS); end
        checks++; if (ct128 !== e128) begin errors++; $display("FAIL rstmid_ct128 got %h want %h", ct128, e128); end
        checks++; if (ct64 !== e64[127:64]) begin errors++; $display("FAIL rstmid_ct64 got %h want %h", ct64, e64[127:64]); end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    task automatic test_random;
        logic [127:0] p, k, e128, e64;
        int n;
        bit early;
        for (int it = 0; it < 6; it++) begin
            p = rand128(); k = rand128();
            e128 = ref_encrypt(p, k, 128);
            e64  = ref_encrypt(p, k, 64);
            early = 1'($urandom_range(0, 1));
            out_ready = early;
            accept_block(p, k);
            wait_valid(n);
            checks++; if (n !== ROUNDS) begin errors++; $display("FAIL rand%0d_latency got %0d want %0d", it, n, ROUNDS); end
            checks++; if (ct128 !== e128) begin errors++; $display("FAIL rand%0d_ct128 got %h want %h", it, ct128, e128); end
            checks++; if (ct64 !== e64[127:64]) begin errors++; $display("FAIL rand%0d_ct64 got %h want %h", it, ct64, e64[127:64]); end
            if (!early) begin
                repeat ($urandom_range(1, 6)) @(posedge clk);
                #1;
                checks++; if (ct128 !== e128 || ov128 !== 1'b1) begin
                    errors++; $display("FAIL rand%0d_hold got ov=%b ct=%h want ov=1 ct=%h", it, ov128, ct128, e128);
                end
                out_ready = 1'b1;
            end
            @(posedge clk); #1;
            out_ready = 1'b0;
            checks++; if (ir128 !== 1'b1 || ir64 !== 1'b1 || ov128 !== 1'b0 || ov64 !== 1'b0) begin
                errors++; $display("FAIL rand%0d_hs got ir=%b%b ov=%b%b want ir=11 ov=00", it, ir128, ir64, ov128, ov64);
            end
        end
    endtask

`ifdef SHIFT_AES_ABORT_EN
    task automatic test_abort;
        int n;
        accept_block(rand128(), rand128());
        repeat (3) @(posedge clk);
        #1;
        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        checks++; if (ir128 !== 1'b1 || ov128 !== 1'b0 || ir64 !== 1'b1 || ov64 !== 1'b0) begin
            errors++; $display("FAIL abort_round got ir=%b%b ov=%b%b want ir=11 ov=00", ir128, ir64, ov128, ov64);
        end
        accept_block(rand128(), rand128());
        wait_valid(n);
        checks++; if (n !== ROUNDS) begin errors++; $display("FAIL abort_latency got %0d want %0d", n, ROUNDS); end
        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        checks++; if (ir128 !== 1'b1 || ov128 !== 1'b0 || ir64 !== 1'b1 || ov64 !== 1'b0) begin
            errors++; $display("FAIL abort_done got ir=%b%b ov=%b%b want ir=11 ov=00", ir128, ir64, ov128, ov64);
        end
    endtask
`endif

    initial begin
        build_sbox();
        test_reset();
        test_fips();
        test_vec64();
        test_backpressure();
        test_back_to_back();
        test_reset_mid();
        test_random();
`ifdef SHIFT_AES_ABORT_EN
        test_abort();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
